// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file defaults and types
package mips_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int REG_ZERO = 0;
  typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [DEF_DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/mips_scoreboard.sv
// mips_scoreboard: pending-write busy bits with set-over-clear priority and a live count
module mips_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    set_en,
  input  logic [ADDR_WIDTH-1:0]   set_idx,
  input  logic                    clr_en,
  input  logic [ADDR_WIDTH-1:0]   clr_idx,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic [ADDR_WIDTH:0]     pending_count
);
  logic do_set, do_clr, rise, fall;
  assign do_set = set_en && set_idx != ADDR_WIDTH'(REG_ZERO);
  assign do_clr = clr_en && clr_idx != ADDR_WIDTH'(REG_ZERO);
  assign rise = do_set && !busy[set_idx];
  // a clear hidden by a same-register set is not a 1->0 transition
  assign fall = do_clr && busy[clr_idx] && !(do_set && set_idx == clr_idx);
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      pending_count <= '0;
    end else begin
      if (do_clr) busy[clr_idx] <= 1'b0;
      if (do_set) busy[set_idx] <= 1'b1;
      pending_count <= pending_count + (ADDR_WIDTH+1)'(rise) - (ADDR_WIDTH+1)'(fall);
    end
  end
endmodule

// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: 2R/1W register file with zero register, optional bypass and scoreboard
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  signal_reg_write,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_reg,
  input  logic                  use_1,
  input  logic                  use_2,
  output logic                  busy_1,
  output logic                  busy_2,
  output logic                  stall,
  output logic [ADDR_WIDTH:0]   pending_count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic wr, hit_1, hit_2;
  assign wr = signal_reg_write && write_reg != ZERO && !reset;
  assign hit_1 = BYPASS != 0 && wr && write_reg == read_reg_1;
  assign hit_2 = BYPASS != 0 && wr && write_reg == read_reg_2;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr) begin
      regs[write_reg] <= write_data;
    end
  end
  always_comb begin
    read_data_1 = read_reg_1 == ZERO ? '0 : hit_1 ? write_data : regs[read_reg_1];
    read_data_2 = read_reg_2 == ZERO ? '0 : hit_2 ? write_data : regs[read_reg_2];
    busy_1 = busy[read_reg_1] && read_reg_1 != ZERO && !hit_1;
    busy_2 = busy[read_reg_2] && read_reg_2 != ZERO && !hit_2;
    stall = (busy_1 && use_1) || (busy_2 && use_2);
  end
  mips_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk(clk),
    .reset(reset),
    .set_en(issue_valid),
    .set_idx(issue_reg),
    .clr_en(signal_reg_write),
    .clr_idx(write_reg),
    .busy(busy),
    .pending_count(pending_count)
  );
endmodule
